// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_ctrl_if
// Brief  : Command port and external-ALU port bundle for alu_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_seq_ctrl_if;
    logic        start;
    logic [2:0]  cmd;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_r;
    logic        alu_zero;
    logic        alu_ovfl;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zero_flag;
    logic        ovfl_flag;

    // Master issues commands and hosts the ALU; slave is the sequencer.
    modport master (
        output start, cmd, opa, opb, alu_r, alu_zero, alu_ovfl,
        input  alu_a, alu_b, alu_op, busy, done, result, zero_flag, ovfl_flag
    );

    modport slave (
        input  start, cmd, opa, opb, alu_r, alu_zero, alu_ovfl,
        output alu_a, alu_b, alu_op, busy, done, result, zero_flag, ovfl_flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_ctrl
// Brief  : Sequences single ALU ops and a 16-cycle shift-add multiply.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq_ctrl (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b011;
    localparam logic [2:0] c_CMD_MUL = 3'b110;
    localparam logic [2:0] c_CMD_RSV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cmd;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [3:0]  r_cnt;
    logic        r_ovfl_acc;
    logic [15:0] r_result;
    logic        r_zero;
    logic        r_ovfl;

    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic [2:0]  w_alu_op;
    logic [15:0] w_acc_nxt;
    logic        w_ovfl_acc_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_alu_a        = 16'd0;
        w_alu_b        = 16'd0;
        w_alu_op       = c_OP_AND;
        w_acc_nxt      = r_acc;
        w_ovfl_acc_nxt = r_ovfl_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_state_nxt = (bus.cmd == c_CMD_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: begin
                if (r_cmd != c_CMD_RSV) begin
                    w_alu_a  = r_opa;
                    w_alu_b  = r_opb;
                    w_alu_op = r_cmd;
                end
                w_state_nxt = S_DONE;
            end
            S_MUL: begin
                w_alu_a  = r_acc;
                w_alu_b  = r_mcand;
                w_alu_op = c_OP_ADD;
                if (r_mplier[0]) begin
                    w_acc_nxt      = bus.alu_r;
                    w_ovfl_acc_nxt = w_ovfl_acc_nxt | bus.alu_ovfl;
                end
                // A set mcand MSB is shifted out while later multiplier bits still need it.
                if (r_mcand[15] && (r_mplier[15:1] != 15'd0))
                    w_ovfl_acc_nxt = 1'b1;
                if (r_cnt == 4'd15)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= 3'd0;
            r_opa      <= 16'd0;
            r_opb      <= 16'd0;
            r_acc      <= 16'd0;
            r_mcand    <= 16'd0;
            r_mplier   <= 16'd0;
            r_cnt      <= 4'd0;
            r_ovfl_acc <= 1'b0;
            r_result   <= 16'd0;
            r_zero     <= 1'b0;
            r_ovfl     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cmd      <= bus.cmd;
                        r_opa      <= bus.opa;
                        r_opb      <= bus.opb;
                        r_acc      <= 16'd0;
                        r_mcand    <= bus.opa;
                        r_mplier   <= bus.opb;
                        r_cnt      <= 4'd0;
                        r_ovfl_acc <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (r_cmd == c_CMD_RSV) begin
                        r_result <= 16'd0;
                        r_zero   <= 1'b1;
                        r_ovfl   <= 1'b1;
                    end else begin
                        r_result <= bus.alu_r;
                        r_zero   <= bus.alu_zero;
                        r_ovfl   <= bus.alu_ovfl;
                    end
                end
                S_MUL: begin
                    r_acc      <= w_acc_nxt;
                    r_ovfl_acc <= w_ovfl_acc_nxt;
                    r_mcand    <= {r_mcand[14:0], 1'b0};
                    r_mplier   <= {1'b0, r_mplier[15:1]};
                    r_cnt      <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_result <= w_acc_nxt;
                        r_zero   <= (w_acc_nxt == 16'd0);
                        r_ovfl   <= w_ovfl_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero_flag = r_zero;
    assign bus.ovfl_flag = r_ovfl;
endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-002 SHALL have port start input 1, command request, sampled only in IDLE.
REQ-003 SHALL have port cmd input 3: 000 AND, 001 OR, 010 NOR, 011 ADD, 100 SUB, 101 SLT, 110 MUL, 111 reserved.
REQ-004 SHALL have ports opa input 16 and opb input 16: operands, sampled with start.
REQ-005 SHALL have ports alu_a output 16, alu_b output 16, alu_op output 3: drive the external 16-bit ALU.
REQ-006 SHALL have ports alu_r input 16, alu_zero input 1, alu_ovfl input 1: ALU result and flags, combinational from alu_a, alu_b and alu_op.
REQ-007 SHALL have port busy output 1, high whenever state is not IDLE.
REQ-008 SHALL have port done output 1, a one-cycle pulse when result is valid.
REQ-009 SHALL have port result output 16, registered, held until the next accepted command.
REQ-010 SHALL have ports zero_flag output 1 and ovfl_flag output 1, registered, updated with result.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL, DONE.
REQ-012 In IDLE with start=1: SHALL latch cmd, opa and opb, clear ovfl_acc, and go to EXEC (cmd 000-101 or 111) or MUL (cmd 110).
REQ-013 With start=0 in IDLE: SHALL stay in IDLE; start in any other state SHALL be ignored, with no queuing.
REQ-014 EXEC, cmd 000-101: SHALL drive alu_a=opa_q, alu_b=opb_q, alu_op=cmd_q for one cycle.
REQ-015 At the end of EXEC: SHALL register result<=alu_r, zero_flag<=alu_zero, ovfl_flag<=alu_ovfl, then go to DONE.
REQ-016 EXEC, cmd 111: SHALL register result=0x0000, zero_flag=1, ovfl_flag=1 and go to DONE, with alu_op held at 000.
REQ-017 MUL is unsigned shift-add over exactly 16 cycles; entry values are acc=0, mcand=opa_q, mplier=opb_q and cnt=0.
REQ-018 Each MUL cycle: SHALL drive alu_a=acc, alu_b=mcand, alu_op=011.
REQ-019 Each MUL cycle with mplier[0]=1: SHALL set acc<=alu_r and ovfl_acc|=alu_ovfl.
REQ-020 Each MUL cycle: SHALL set mcand<=mcand<<1, mplier<=mplier>>1 and cnt<=cnt+1.
REQ-021 SHALL set ovfl_acc|=1 in any MUL cycle where mcand[15]=1 and mplier[15:1]!=0, because a set bit is lost.
REQ-022 When cnt=15 completes: SHALL register result=final acc (low 16 bits of the product), zero_flag=(result==0), ovfl_flag=ovfl_acc, then go to DONE.
REQ-023 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-024 Latency from the start-sampling edge to the done cycle: SHALL be 2 cycles for cmd 000-101 and 111, and 17 cycles for MUL.
REQ-025 A new start may be sampled in the first IDLE cycle after DONE, giving back-to-back throughput of one single-op command per 3 cycles.
REQ-026 In IDLE and DONE: SHALL drive alu_a=0, alu_b=0, alu_op=000.
REQ-027 MUL with opa=0 or opb=0: SHALL still take 16 cycles and give result=0, zero_flag=1, ovfl_flag=0.
REQ-028 Operand registers SHALL be isolated from opa and opb after acceptance, so input changes during busy have no effect.

Reset
REQ-029 rst_n=0: SHALL force asynchronously state=IDLE, busy=0, done=0, result=0x0000, zero_flag=0, ovfl_flag=0, alu_a=0, alu_b=0, alu_op=000, and all internal registers to 0.
REQ-030 Reset mid-EXEC or mid-MUL: SHALL abort the command with no done pulse and leave result at 0x0000.
REQ-031 After rst_n deasserts: SHALL accept start on the first rising edge with rst_n=1.

Verification
REQ-032 ADD test: cmd=011, opa=0x0005, opb=0x0003 -> done 2 cycles after start with result=0x0008, zero_flag=0, ovfl_flag=0.
REQ-033 SUB test: cmd=100, opa=0x1234, opb=0x1234 -> result=0x0000, zero_flag=1, done pulse width exactly 1 cycle.
REQ-034 MUL tests:
- cmd=110, opa=0x0003, opb=0x0005 -> busy for 17 cycles, done on cycle 17, result=0x000F, ovfl_flag=0.
- cmd=110, opa=0x0100, opb=0x0100 -> result=0x0000, ovfl_flag=1.
REQ-035 Ignored start: a second start with different cmd and operands during MUL -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-036 Reset and reserved cmd:
- rst_n pulsed low at MUL cycle 8 -> busy=0, result=0x0000 immediately, no done pulse.
- cmd=111 -> result=0x0000, zero_flag=1, ovfl_flag=1.
